// File: rtl/hilo_divu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_divu_pkg
//  Description : Shared constants for the HI/LO register / divide unit:
//                op encoding, FSM state encoding and default datapath width.
//  Revision    : 1.0  initial release
// ============================================================================
package hilo_divu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage : hilo_divu_pkg
`default_nettype wire

// File: rtl/hilo_divu_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_divu_if
//  Description : Request / result bundle between the pipeline controller
//                (master) and the HI/LO divide unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface hilo_divu_if #(
    parameter int WIDTH = hilo_divu_pkg::WIDTH_DEF
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, op, a, b, alu_lo, alu_hi,
        input  hi, lo, busy, done, dbz
    );

    modport slave (
        input  start, op, a, b, alu_lo, alu_hi,
        output hi, lo, busy, done, dbz
    );

endinterface : hilo_divu_if
`default_nettype wire

// File: rtl/hilo_divu_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_divu_div_step
//  Description : One restoring radix-2 divide iteration. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor and shifts the resulting quotient bit in at the LSB.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_divu_div_step #(
    parameter int WIDTH = hilo_divu_pkg::WIDTH_DEF
) (
    input  wire logic [WIDTH:0]   rem_i,
    input  wire logic [WIDTH-1:0] quo_i,
    input  wire logic [WIDTH-1:0] dvs_i,
    output logic      [WIDTH:0]   rem_o,
    output logic      [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] trial;
    logic           ge;

    // Shifted partial remainder needs WIDTH+1 bits: it can reach 2*divisor-1.
    assign trial = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    // A set top bit in the incoming remainder would mean the shifted value
    // overflowed WIDTH+1 bits, which is always >= any divisor.
    assign ge    = rem_i[WIDTH] | (trial >= {1'b0, dvs_i});

    // Restore (keep trial) when the subtraction would go negative.
    always_comb begin
        rem_o = trial;
        quo_o = {quo_i[WIDTH-2:0], ge};
        if (ge) begin
            rem_o = trial - {1'b0, dvs_i};
        end
    end

endmodule : hilo_divu_div_step
`default_nettype wire

// File: rtl/hilo_divu.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_divu
//  Description : HI/LO result registers for the mMIPS datapath. Captures the
//                ALU product on MULTU, serves MTHI/MTLO, and performs a
//                multi-cycle restoring unsigned divide (DIVU) that writes
//                quotient to LO and remainder to HI. busy stalls the pipeline.
//                Optional macro HILO_SIGNED_DIV_EN adds signed DIV on op=4.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_divu
    import hilo_divu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    hilo_divu_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

`ifdef HILO_SIGNED_DIV_EN
    logic is_sdiv;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    // Signed divide runs on magnitudes; signs are reapplied at write-back.
    assign is_sdiv = (bus.op == OP_DIV);
    assign a_mag   = (is_sdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag   = (is_sdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign quo_res = neg_quo_q ? -quo_q : quo_q;
    assign rem_res = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`else
    assign a_mag   = bus.a;
    assign b_mag   = bus.b;
    assign quo_res = quo_q;
    assign rem_res = rem_q[WIDTH-1:0];
`endif

    hilo_divu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // State and datapath registers; reset abandons any divide in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef HILO_SIGNED_DIV_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
`ifdef HILO_SIGNED_DIV_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // Next-state logic: op dispatch in IDLE, one quotient bit per RUN cycle,
    // result write-back in WB.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
`ifdef HILO_SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULTU: begin
                            hi_d  = bus.alu_hi;
                            lo_d  = bus.alu_lo;
                            dbz_d = 1'b0;
                        end
                        OP_MTHI: begin
                            hi_d  = bus.a;
                            dbz_d = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d  = bus.a;
                            dbz_d = 1'b0;
                        end
`ifdef HILO_SIGNED_DIV_EN
                        OP_DIVU, OP_DIV: begin
`else
                        OP_DIVU: begin
`endif
                            if (bus.b == '0) begin
                                // Divide by zero resolves immediately.
                                lo_d   = '1;
                                hi_d   = bus.a;
                                dbz_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                quo_d   = a_mag;
                                dvs_d   = b_mag;
                                rem_d   = '0;
                                cnt_d   = '0;
                                dbz_d   = 1'b0;
                                state_d = ST_RUN;
`ifdef HILO_SIGNED_DIV_EN
                                neg_quo_d = is_sdiv & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_rem_d = is_sdiv & bus.a[WIDTH-1];
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                lo_d    = quo_res;
                hi_d    = rem_res;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;

endmodule : hilo_divu
`default_nettype wire

// File: tb/tb_hilo_divu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_divu
//  Description : Directed self-checking bench for hilo_divu (WIDTH=32).
//                Signed DIV vectors run when HILO_SIGNED_DIV_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_divu;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   ncyc;

    hilo_divu_if #(.WIDTH(WIDTH)) bus ();

    hilo_divu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; afterwards we sit just past the accept edge.
    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Count cycles with busy high; bounded so a stuck unit cannot hang the run.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        bus.alu_lo = '0;
        bus.alu_hi = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_hi",   bus.hi,   32'h0);
        check("rst_lo",   bus.lo,   32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_dbz",  32'(bus.dbz),  32'h0);

        // MULTU capture
        bus.alu_hi = 32'h0000_0001;
        bus.alu_lo = 32'h0000_0000;
        issue(3'd0, 32'h0, 32'h0);
        check("multu_hi",   bus.hi, 32'h0000_0001);
        check("multu_lo",   bus.lo, 32'h0000_0000);
        check("multu_busy", 32'(bus.busy), 32'h0);

        // DIVU 100 / 7: 33 busy cycles, q=14 r=2, one-cycle done
        issue(3'd1, 32'd100, 32'd7);
        wait_idle(ncyc);
        check("divu_busy_cycles", 32'(ncyc), 32'd33);
        check("divu_lo",   bus.lo, 32'd14);
        check("divu_hi",   bus.hi, 32'd2);
        check("divu_done", 32'(bus.done), 32'h1);
        tick();
        check("divu_done_clr", 32'(bus.done), 32'h0);

        // Divide by zero
        issue(3'd1, 32'h1234_5678, 32'h0);
        check("dbz_lo",   bus.lo, 32'hFFFF_FFFF);
        check("dbz_hi",   bus.hi, 32'h1234_5678);
        check("dbz_flag", 32'(bus.dbz),  32'h1);
        check("dbz_busy", 32'(bus.busy), 32'h0);
        check("dbz_done", 32'(bus.done), 32'h1);
        tick();
        check("dbz_sticky", 32'(bus.dbz), 32'h1);
        issue(3'd3, 32'd5, 32'h0);
        check("mtlo_lo",      bus.lo, 32'd5);
        check("mtlo_dbz_clr", 32'(bus.dbz), 32'h0);

        // Start while busy ignored: 1000 / 33 -> q=30 r=10
        issue(3'd1, 32'd1000, 32'd33);
        for (int i = 0; i < 9; i++) tick();
        check("run_hi_hold", bus.hi, 32'h1234_5678);
        check("run_lo_hold", bus.lo, 32'd5);
        issue(3'd2, 32'h0000_00AA, 32'h0);
        wait_idle(ncyc);
        check("ign_busy_cycles", 32'(ncyc), 32'd23);
        check("ign_hi", bus.hi, 32'd10);
        check("ign_lo", bus.lo, 32'd30);
        tick();

        // Reset mid-divide
        issue(3'd1, 32'd1000, 32'd3);
        for (int i = 0; i < 19; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_hi",   bus.hi, 32'h0);
        check("abort_lo",   bus.lo, 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check("abort_done_late", 32'(bus.done), 32'h0);
        check("abort_lo_late",   bus.lo, 32'h0);

        // Boundary divides
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0010);
        wait_idle(ncyc);
        check("max_lo", bus.lo, 32'h0FFF_FFFF);
        check("max_hi", bus.hi, 32'h0000_000F);
        issue(3'd1, 32'd5, 32'd9);
        wait_idle(ncyc);
        check("small_lo", bus.lo, 32'd0);
        check("small_hi", bus.hi, 32'd5);
        issue(3'd1, 32'hFFFF_FFFF, 32'h1);
        wait_idle(ncyc);
        check("div1_lo", bus.lo, 32'hFFFF_FFFF);
        check("div1_hi", bus.hi, 32'h0);

        // MTHI / MTLO and invalid op
        issue(3'd2, 32'hDEAD_BEEF, 32'h0);
        issue(3'd3, 32'hCAFE_BABE, 32'h0);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mtlo_lo2", bus.lo, 32'hCAFE_BABE);
        bus.alu_hi = 32'h1111_1111;
        bus.alu_lo = 32'h2222_2222;
        issue(3'd6, 32'h3333_3333, 32'h0);
        check("nop6_hi",   bus.hi, 32'hDEAD_BEEF);
        check("nop6_lo",   bus.lo, 32'hCAFE_BABE);
        check("nop6_busy", 32'(bus.busy), 32'h0);

`ifdef HILO_SIGNED_DIV_EN
        // Signed DIV
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle(ncyc);
        check("sdiv_cycles", 32'(ncyc), 32'd33);
        check("sdiv_lo", bus.lo, 32'hFFFF_FFFD);
        check("sdiv_hi", bus.hi, 32'hFFFF_FFFF);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(ncyc);
        check("sdiv_ovf_lo", bus.lo, 32'h8000_0000);
        check("sdiv_ovf_hi", bus.hi, 32'h0);
        issue(3'd4, 32'h0000_0009, 32'h0);
        check("sdiv_dbz_lo",  bus.lo, 32'hFFFF_FFFF);
        check("sdiv_dbz_hi",  bus.hi, 32'h0000_0009);
        check("sdiv_dbz_flg", 32'(bus.dbz), 32'h1);
`else
        // op=4 is a no-op without the signed option
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        check("nop4_busy", 32'(bus.busy), 32'h0);
        check("nop4_hi",   bus.hi, 32'hDEAD_BEEF);
        check("nop4_lo",   bus.lo, 32'hCAFE_BABE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hilo_divu
`default_nettype wire

// File: doc/hilo_divu.md
Name: hilo_divu

Overview:
- HI/LO result-register unit of the mMIPS datapath. Consumes the ALU's product outputs: low word into LO, high word into HI on MULTU.
- Adds the multi-cycle unsigned divide the combinational ALU lacks.
- Serves MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO. Raises busy so the controller stalls the pipeline during division.

Parameters:
- WIDTH, 32, operand/register width; the divide runs WIDTH iterations.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle op request; sampled only while busy=0
- op  in  3  0=MULTU capture, 1=DIVU, 2=MTHI, 3=MTLO, 4=DIV signed (macro only), 5-7 no-op
- a  in  WIDTH  dividend / MTHI-MTLO source (rs)
- b  in  WIDTH  divisor (rt)
- alu_lo  in  WIDTH  ALU r (product low)
- alu_hi  in  WIDTH  ALU r2 (product high)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  divide in progress
- done  out  1  one-cycle pulse when a DIVU/DIV result is written
- dbz  out  1  sticky divide-by-zero flag, cleared by next accepted start

Behaviour:
- Reset (rst_n=0 at clk edge): hi=0, lo=0, busy=0, done=0, dbz=0, FSM=IDLE. Reset mid-divide aborts the operation; no partial result is written.
- FSM states: IDLE, RUN, WB.
- IDLE with start=1 and op=0: hi<=alu_hi, lo<=alu_lo at the same edge. Single cycle; busy stays 0.
- IDLE with start=1 and op=2: hi<=a. With op=3: lo<=a. Single cycle.
- IDLE with start=1 and op=1:
  - b==0: single cycle, no RUN. lo<=all-ones, hi<=a, dbz<=1, done pulses next cycle.
  - b!=0: latch a, b; clear partial remainder; go RUN; dbz<=0.
- RUN: restoring radix-2, one quotient bit per cycle, MSB first.
  - Remainder is WIDTH+1 bits to avoid overflow.
  - After WIDTH iterations (5-bit counter, 0..WIDTH-1), go WB.
- WB: lo<=quotient, hi<=remainder; done=1 during the following cycle; return to IDLE.
- Latency: start accepted at edge E0; busy=1 after E0 through E(WIDTH+1); hi/lo updated at edge E(WIDTH+1), i.e. E33 for WIDTH=32. busy=1 for exactly 33 cycles.
- start while busy=1 is ignored (no queuing); the controller must hold the instruction.
- Invalid op with start=1: no state change.
- hi/lo never change during RUN, so MFHI/MFLO issued during busy read the old values. The controller stalls them; the unit does not.
- All arithmetic is unsigned modulo 2^WIDTH; no exceptions are generated.

Optional Feature:
- Macro: HILO_SIGNED_DIV_EN.
- Defined: op=4 performs signed DIV.
  - Operands are converted to magnitudes; the same RUN datapath is used.
  - WB negates the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero behaves as for DIVU.
  - Latency is identical to DIVU.
- Undefined: op=4 is a no-op; no sign logic is synthesized.

Decomposition:
- Shared package holds:
  - op encoding constants: OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO, OP_DIV
  - FSM state encoding
  - WIDTH default
- One natural sub-module: div_step. Combinational single iteration: {rem,quo} in → shifted trial subtract → {rem,quo} out. The top level holds the FSM, counter and HI/LO registers.

Test Plan:
1. alu_hi=0x00000001, alu_lo=0x00000000, start op=0 → next cycle hi=0x00000001, lo=0x00000000, busy never rises.
2. a=100, b=7, op=1 → busy high 33 cycles; then lo=14, hi=2; done high for one cycle.
3. a=0x12345678, b=0, op=1 → next cycle lo=0xFFFFFFFF, hi=0x12345678, dbz=1, busy stays 0; a following MTLO a=5 clears dbz and gives lo=5.
4. DIVU started; start op=2 with a=0xAA issued at cycle 10 → ignored, final hi=remainder. Separately: rst_n=0 at cycle 20 → hi=lo=0, busy=0 next cycle, no done.
5. MTHI a=0xDEADBEEF then MTLO a=0xCAFEBABE → hi/lo hold these values; op=6 → no change.
6. (HILO_SIGNED_DIV_EN) a=-7, b=2, op=4 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). a=0x80000000, b=-1 → lo=0x80000000, hi=0.
